// File: rtl/bg_line_renderer.sv
// bg_line_renderer: renders one background scanline from VRAM into a 2-bit pixel stream.
// Optional feature macro BG_PALETTE_EN: when defined, pixels are mapped through bgp;
// otherwise the raw colour index is emitted and bgp is ignored.
module bg_line_renderer #(
   parameter int LINE_WIDTH = 160,
   parameter int LCD_LINES  = 144,
   parameter int VRAM_AW    = 13
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [7:0]         line,
   input  logic [7:0]         scx,
   input  logic [7:0]         scy,
   input  logic               map_sel,
   input  logic               tile_sel,
   input  logic               bg_en,
   input  logic [7:0]         bgp,
   output logic               vram_rd,
   output logic [VRAM_AW-1:0] vram_addr,
   input  logic [7:0]         vram_rdata,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [1:0]         pix_data,
   output logic [7:0]         pix_x,
   output logic               pix_last,
   output logic               busy,
   output logic               done
);
   typedef enum logic [2:0] {IDLE, MAP_REQ, MAP_WAIT, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, PUSH} state_t;
   localparam logic [7:0] XLAST = 8'(LINE_WIDTH - 1);
   localparam logic [8:0] LINES_LIM = 9'(LCD_LINES);
   state_t state;
   logic [7:0] scx_q, bgy_q, lo, hi;
   logic map_q, tile_q, bgen_q;
   logic [7:0] sbgy, nx, cbgx, nbgx;
`ifdef BG_PALETTE_EN
   logic [7:0] bgp_q;
`else
   logic unused_bgp;
   assign unused_bgp = ^bgp;
`endif
   assign sbgy = scy + line;
   assign nx   = pix_x + 8'd1;
   assign cbgx = scx_q + pix_x;
   assign nbgx = scx_q + nx;

   function automatic logic [VRAM_AW-1:0] map_addr(input logic [7:0] y, input logic [7:0] bx, input logic sel);
      return VRAM_AW'(sel ? 13'h1C00 : 13'h1800) + VRAM_AW'({y[7:3], 5'd0}) + VRAM_AW'(bx[7:3]);
   endfunction

   function automatic logic [VRAM_AW-1:0] tile_addr(input logic [7:0] idx, input logic [2:0] row, input logic sel);
      logic [12:0] a;
      a = sel ? {1'b0, idx, 4'd0} : 13'h1000 + {idx[7], idx, 4'd0};
      return VRAM_AW'(a + {9'd0, row, 1'b0});
   endfunction

   function automatic logic [1:0] shade(input logic [7:0] h, input logic [7:0] l, input logic [2:0] b);
      logic [1:0] c;
      c = {h[~b], l[~b]};
`ifdef BG_PALETTE_EN
      return bgp_q[{c, 1'b0} +: 2];
`else
      return c;
`endif
   endfunction

   // fetch/push sequencer with all outputs registered
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         vram_rd   <= 1'b0;
         vram_addr <= '0;
         pix_valid <= 1'b0;
         pix_data  <= 2'd0;
         pix_x     <= 8'd0;
         pix_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         scx_q     <= 8'd0;
         bgy_q     <= 8'd0;
         lo        <= 8'd0;
         hi        <= 8'd0;
         map_q     <= 1'b0;
         tile_q    <= 1'b0;
         bgen_q    <= 1'b0;
`ifdef BG_PALETTE_EN
         bgp_q     <= 8'd0;
`endif
      end else begin
         vram_rd <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: if (start) begin
               if ({1'b0, line} >= LINES_LIM) done <= 1'b1;
               else begin
                  scx_q  <= scx;
                  bgy_q  <= sbgy;
                  map_q  <= map_sel;
                  tile_q <= tile_sel;
                  bgen_q <= bg_en;
`ifdef BG_PALETTE_EN
                  bgp_q  <= bgp;
`endif
                  busy   <= 1'b1;
                  pix_x  <= 8'd0;
                  if (bg_en) begin
                     state     <= MAP_REQ;
                     vram_rd   <= 1'b1;
                     vram_addr <= map_addr(sbgy, scx, map_sel);
                  end else begin
                     state     <= PUSH;
                     pix_valid <= 1'b1;
                     pix_data  <= 2'd0;
                     pix_last  <= (LINE_WIDTH == 1);
                  end
               end
            end
            MAP_REQ: state <= MAP_WAIT;
            MAP_WAIT: begin
               state     <= LO_REQ;
               vram_rd   <= 1'b1;
               vram_addr <= tile_addr(vram_rdata, bgy_q[2:0], tile_q);
            end
            LO_REQ: state <= LO_WAIT;
            LO_WAIT: begin
               lo        <= vram_rdata;
               state     <= HI_REQ;
               vram_rd   <= 1'b1;
               vram_addr <= {vram_addr[VRAM_AW-1:1], 1'b1};
            end
            HI_REQ: state <= HI_WAIT;
            HI_WAIT: begin
               hi        <= vram_rdata;
               state     <= PUSH;
               pix_valid <= 1'b1;
               pix_data  <= shade(vram_rdata, lo, cbgx[2:0]);
               pix_last  <= (pix_x == XLAST);
            end
            PUSH: if (pix_ready) begin
               if (pix_last) begin
                  state     <= IDLE;
                  pix_valid <= 1'b0;
                  pix_last  <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  pix_x <= nx;
                  if (bgen_q && cbgx[2:0] == 3'd7) begin
                     state     <= MAP_REQ;
                     pix_valid <= 1'b0;
                     vram_rd   <= 1'b1;
                     vram_addr <= map_addr(bgy_q, nbgx, map_q);
                  end else begin
                     pix_data <= bgen_q ? shade(hi, lo, nbgx[2:0]) : 2'd0;
                     pix_last <= (nx == XLAST);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/bg_line_renderer.md
# bg_line_renderer

Parametrised background scanline renderer for the video subsystem. On a `start` pulse it walks one LCD line tile by tile. For each tile it fetches the tile-map byte and two tile-data bytes from VRAM over a single-port read interface with 1-cycle latency. It then streams `LINE_WIDTH` 2-bit pixels through a valid/ready handshake to the LCD frame store. It sits between the VRAM/register block and the LCD, and supports scroll wrap-around, both map bases and both tile-data addressing modes.

## Interface
- `LINE_WIDTH`, 160, pixels emitted per line (1..256)
- `LCD_LINES`, 144, number of visible lines; `line` values at or above this are rejected
- `VRAM_AW`, 13, VRAM offset width (offset from 0x8000)

Ports (clock and reset first):
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high
- `start` in 1: one-cycle request to render `line`
- `line` in 8: line number
- `scx`, `scy` in 8 each: scroll registers (FF43/FF42)
- `map_sel` in 1: LCDC bit 3; 0 selects map 0x1800, 1 selects 0x1C00
- `tile_sel` in 1: LCDC bit 4; 1 is unsigned at 0x0000, 0 is signed at 0x1000
- `bg_en` in 1: LCDC bit 0
- `bgp` in 8: background palette (FF47)
- `vram_rd` out 1: read strobe
- `vram_addr` out `VRAM_AW`: read offset
- `vram_rdata` in 8: read data, valid the cycle after `vram_rd`
- `pix_valid` out 1: pixel available
- `pix_ready` in 1: consumer accepts the pixel
- `pix_data` out 2: shade
- `pix_x` out 8: pixel column
- `pix_last` out 1: final pixel of the line
- `busy` out 1: line in progress
- `done` out 1: one-cycle pulse when the line completes

## Operation
- `start` is sampled only in IDLE; it is ignored while `busy`.
- On an accepted `start`, the block latches `line`, `scx`, `scy`, `map_sel`, `tile_sel`, `bg_en` and `bgp`. Later changes to these inputs do not affect the line in flight.
- States: IDLE → MAP_REQ → MAP_WAIT → LO_REQ → LO_WAIT → HI_REQ → HI_WAIT → PUSH. PUSH returns to MAP_REQ for the next tile, or goes to IDLE after the last pixel.
  - REQ states drive `vram_rd=1` with the address.
  - WAIT states capture `vram_rdata`.
- Arithmetic is 8-bit mod 256, so both axes wrap at 256:
  - `bgY = scy + line`
  - `bgX = scx + x`
- Map address: `base + (bgY[7:3] << 5) + bgX[7:3]`.
- Tile address, where `idx` is the map byte and `row = bgY[2:0]`:
  - `tile_sel=1`: `idx*16 + row*2`
  - `tile_sel=0`: `0x1000 + $signed(idx)*16 + row*2`
  - The hi byte is at the lo address + 1.
- Colour is `{hi[7-bgX[2:0]], lo[7-bgX[2:0]]}`.
- The first tile starts at bit `scx[2:0]`. PUSH emits pixels until the tile's bit 0 or until `x = LINE_WIDTH-1`.
- `bg_en=0`: no VRAM reads; the block emits `LINE_WIDTH` pixels of shade 0 directly from PUSH.
- `line >= LCD_LINES`: no reads and no pixels; `done` pulses the cycle after `start`.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset mid-line abandons the line with no `done` and no further reads.
- Latency from `start` sampled in cycle 0:
  - cycle 1: `busy=1`, MAP_REQ
  - cycle 7: first `pix_valid`
- Tile cost is 6 fetch cycles plus one cycle per accepted pixel; fetch is never overlapped with push.
- Handshake:
  - `pix_data`, `pix_x` and `pix_last` are stable while `pix_valid && !pix_ready`.
  - A transfer happens on `pix_valid && pix_ready`.
  - `pix_valid` may be high in consecutive cycles.
- `pix_last` is high only with `pix_x = LINE_WIDTH-1`.
- `done` pulses, and `busy` falls, in the cycle after the last transfer. The block accepts a new `start` in that same cycle.

## Configuration
- `BG_PALETTE_EN` defined: `pix_data = bgp[2c+1:2c]`, where `c` is the colour index.
- `BG_PALETTE_EN` undefined: `pix_data = c` (raw index) and the `bgp` input is unused.

## Test plan
- Map 0x1800 filled with 0x01; tile 1 row 0 lo=0xFF, hi=0x00; `scx=scy=line=0`, `bgp=0xE4`, `pix_ready=1` → 160 pixels of shade 1, first valid at cycle 7, `pix_last` at x=159, `done` one cycle later.
- Every tile's row 0 lo=0x80, hi=0x80; `scx=3` → colour 3 exactly at x=5, 13, 21 …; all other pixels 0.
- `tile_sel=0`, map byte 0x80, `scy=2`, `line=0` → first lo read at offset 0x0804, hi at 0x0805.
- `pix_ready` toggling 1/0 every cycle → 160 transfers, no loss or duplication, outputs stable while stalled.
- `scx=0xFC`, `scy=0xFF`, `line=1`, `map_sel=1` → map reads wrap: first address 0x1C1F, then 0x1C00; rows use `bgY=0`.
- `line=144` → `done` at cycle 1 with no `vram_rd`; `reset` asserted at pixel 40 of a line → all outputs 0 next cycle, no `done`.
